// File: rtl/risc_mem_pkg.sv
// Purpose : shared types, widths and region decode for the RISC memory responder.
// Latency : n/a (package).
// Backpressure: n/a (package).
package risc_mem_pkg;

    localparam int          ADDR_W     = 13;
    localparam int          DATA_W     = 8;
    localparam int          RAM_AW     = 10;
    localparam int          WAIT_W     = 4;
    localparam logic [1:0]  RAM_REGION = 2'b11;

    typedef enum logic {
        REG_ROM,
        REG_RAM
    } region_e;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP,
        RELEASE
    } state_e;

    // The top two address bits pick the region; everything else is ROM.
    // The shift form keeps the whole address in the expression, so the
    // low bits do not look like dead inputs.
    function automatic region_e decode_region(input logic [ADDR_W-1:0] addr);
        return ((addr >> (ADDR_W - 2)) == ADDR_W'(RAM_REGION)) ? REG_RAM : REG_ROM;
    endfunction

endpackage

// File: rtl/risc_addr_decode.sv
// Purpose : combinational CPU address -> ROM/RAM region select.
// Latency : 0 cycles (pure combinational).
// Backpressure: none; always produces a select.
//
// Ports:
//   i_addr    CPU request address
//   o_rom_sel address falls in the ROM region
//   o_ram_sel address falls in the RAM region (exactly one select is high)
module risc_addr_decode
    import risc_mem_pkg::*;
(
    input  logic [ADDR_W-1:0] i_addr,
    output logic              o_rom_sel,
    output logic              o_ram_sel
);

    region_e w_region;

    always_comb begin
        w_region  = decode_region(i_addr);
        o_ram_sel = (w_region == REG_RAM);
        o_rom_sel = (w_region == REG_ROM);
    end

endmodule

// File: rtl/risc_mem_responder.sv
// Purpose : CPU-bus memory responder; decodes rd/wr to ROM or RAM, drives strobes with wait states.
// Latency : ready at WAIT+2 cycles after acceptance cycle (ROM_WAIT/RAM_WAIT), 1 cycle for errors.
// Backpressure: request levels held until ready; RELEASE waits for rd/wr to drop; halt blocks acceptance.
//
// Ports:
//   i_clk, i_rst                          clock, async active-high reset
//   i_cpu_halt/rd/wr/addr/wdata           CPU request side (levels)
//   o_cpu_rdata/ready/err                 CPU response (ready/err are 1-cycle pulses)
//   o_rom_addr/ena/read, i_rom_data       ROM port
//   o_ram_addr/ena/read/write/wdata, i_ram_rdata  RAM port
module risc_mem_responder
    import risc_mem_pkg::*;
#(
    parameter int unsigned ROM_WAIT = 2,
    parameter int unsigned RAM_WAIT = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_cpu_halt,
    input  logic              i_cpu_rd,
    input  logic              i_cpu_wr,
    input  logic [ADDR_W-1:0] i_cpu_addr,
    input  logic [DATA_W-1:0] i_cpu_wdata,
    output logic [DATA_W-1:0] o_cpu_rdata,
    output logic              o_cpu_ready,
    output logic              o_cpu_err,
    output logic [ADDR_W-1:0] o_rom_addr,
    output logic              o_rom_ena,
    output logic              o_rom_read,
    input  logic [DATA_W-1:0] i_rom_data,
    output logic [RAM_AW-1:0] o_ram_addr,
    output logic              o_ram_ena,
    output logic              o_ram_read,
    output logic              o_ram_write,
    output logic [DATA_W-1:0] o_ram_wdata,
    input  logic [DATA_W-1:0] i_ram_rdata
);

    localparam logic [WAIT_W-1:0] ROM_CNT = WAIT_W'(ROM_WAIT);
    localparam logic [WAIT_W-1:0] RAM_CNT = WAIT_W'(RAM_WAIT);

    state_e             r_state;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_wdata;
    logic [DATA_W-1:0]  r_rdata;
    logic [WAIT_W-1:0]  r_cnt;
    logic               r_is_rd;
    region_e            r_region;
    logic               r_ready;
    logic               r_err;
    logic               r_rom_ena;
    logic               r_rom_read;
    logic               r_ram_ena;
    logic               r_ram_read;
    logic               r_ram_write;

    logic               w_rom_sel;
    logic               w_ram_sel;
    logic               w_one_req;
    logic               w_any_req;
    logic               w_rom_wr;

    risc_addr_decode u_decode (
        .i_addr    (i_cpu_addr),
        .o_rom_sel (w_rom_sel),
        .o_ram_sel (w_ram_sel)
    );

    assign w_one_req = i_cpu_rd ^ i_cpu_wr;
    assign w_any_req = i_cpu_rd | i_cpu_wr;
    assign w_rom_wr  = i_cpu_wr & w_rom_sel;

    // Every output comes straight off a register; the strobes are set on the
    // accepting edge so they appear the cycle after the request is seen.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_cnt       <= '0;
            r_is_rd     <= 1'b0;
            r_region    <= REG_ROM;
            r_ready     <= 1'b0;
            r_err       <= 1'b0;
            r_rom_ena   <= 1'b0;
            r_rom_read  <= 1'b0;
            r_ram_ena   <= 1'b0;
            r_ram_read  <= 1'b0;
            r_ram_write <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!i_cpu_halt) begin
                        if (w_one_req && !w_rom_wr) begin
                            r_addr      <= i_cpu_addr;
                            r_wdata     <= i_cpu_wdata;
                            r_is_rd     <= i_cpu_rd;
                            r_region    <= w_ram_sel ? REG_RAM : REG_ROM;
                            r_cnt       <= w_ram_sel ? RAM_CNT : ROM_CNT;
                            // Only reads reach this branch for the ROM region.
                            r_rom_ena   <= w_rom_sel;
                            r_rom_read  <= w_rom_sel;
                            r_ram_ena   <= w_ram_sel;
                            r_ram_read  <= w_ram_sel & i_cpu_rd;
                            r_ram_write <= w_ram_sel & i_cpu_wr;
                            r_state     <= ACCESS;
                        end else if (w_any_req) begin
                            // Both strobes, or a write into ROM: answer with an
                            // error without touching either memory.
                            r_ready <= 1'b1;
                            r_err   <= 1'b1;
                            r_state <= RESP;
                        end
                    end
                end

                ACCESS: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        // Last strobe cycle: memory data is valid now.
                        if (r_is_rd) begin
                            r_rdata <= (r_region == REG_RAM) ? i_ram_rdata : i_rom_data;
                        end
                        r_rom_ena   <= 1'b0;
                        r_rom_read  <= 1'b0;
                        r_ram_ena   <= 1'b0;
                        r_ram_read  <= 1'b0;
                        r_ram_write <= 1'b0;
                        r_ready     <= 1'b1;
                        r_state     <= RESP;
                    end
                end

                RESP: begin
                    r_ready <= 1'b0;
                    r_err   <= 1'b0;
                    r_state <= RELEASE;
                end

                RELEASE: begin
                    // A request still held from the last transfer must drop
                    // first, otherwise it would be serviced twice.
                    if (!w_any_req) begin
                        r_state <= IDLE;
                    end
                end

                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_cpu_rdata = r_rdata;
    assign o_cpu_ready = r_ready;
    assign o_cpu_err   = r_err;
    assign o_rom_addr  = r_addr;
    assign o_rom_ena   = r_rom_ena;
    assign o_rom_read  = r_rom_read;
    assign o_ram_addr  = r_addr[RAM_AW-1:0];
    assign o_ram_ena   = r_ram_ena;
    assign o_ram_read  = r_ram_read;
    assign o_ram_write = r_ram_write;
    assign o_ram_wdata = r_wdata;

endmodule

// File: tb/tb_risc_mem_responder.sv
// Purpose : directed self-checking bench for risc_mem_responder with a response scoreboard.
// Latency : checks ROM (4), RAM (3) and error (1) cycle latencies.
// Backpressure: exercises held requests, halt, and reset mid-access.
module tb_risc_mem_responder;

    typedef struct packed {
        logic [7:0] rdata;
        logic       err;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        cpu_halt;
    logic        cpu_rd;
    logic        cpu_wr;
    logic [12:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        cpu_ready;
    logic        cpu_err;
    logic [12:0] rom_addr;
    logic        rom_ena;
    logic        rom_read;
    logic [7:0]  rom_data;
    logic [9:0]  ram_addr;
    logic        ram_ena;
    logic        ram_read;
    logic        ram_write;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;

    logic [7:0]  ram_mem [0:1023];
    exp_t        sb_q [$];
    logic [7:0]  sb_last;
    int          n_chk;
    int          n_fail;

    risc_mem_responder #(.ROM_WAIT(2), .RAM_WAIT(1)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_cpu_halt  (cpu_halt),
        .i_cpu_rd    (cpu_rd),
        .i_cpu_wr    (cpu_wr),
        .i_cpu_addr  (cpu_addr),
        .i_cpu_wdata (cpu_wdata),
        .o_cpu_rdata (cpu_rdata),
        .o_cpu_ready (cpu_ready),
        .o_cpu_err   (cpu_err),
        .o_rom_addr  (rom_addr),
        .o_rom_ena   (rom_ena),
        .o_rom_read  (rom_read),
        .i_rom_data  (rom_data),
        .o_ram_addr  (ram_addr),
        .o_ram_ena   (ram_ena),
        .o_ram_read  (ram_read),
        .o_ram_write (ram_write),
        .o_ram_wdata (ram_wdata),
        .i_ram_rdata (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: synchronous write, asynchronous read.
    assign ram_rdata = ram_mem[ram_addr];
    always @(posedge clk) begin
        if (ram_ena && ram_write) ram_mem[ram_addr] <= ram_wdata;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_chk++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [4:0] strobes();
        return {rom_ena, rom_read, ram_ena, ram_read, ram_write};
    endfunction

    function automatic logic [45:0] all_outs();
        return {rom_addr, rom_ena, rom_read, ram_addr, ram_ena, ram_read,
                ram_write, ram_wdata, cpu_rdata, cpu_ready, cpu_err};
    endfunction

    // Called at a negedge. Drives one request, follows it to cpu_ready,
    // holds it `hold` further cycles, then drops it.
    task automatic run_req(input string tag, input logic rd, input logic wr,
                           input logic [12:0] addr, input logic [7:0] wd,
                           input int lat, input logic exp_err,
                           input logic [7:0] rd_val, input int hold);
        logic [4:0] pat;
        logic       is_ram;
        bit         got;
        exp_t       e;
        is_ram = (addr[12:11] == 2'b11);
        if (exp_err)      pat = 5'b00000;
        else if (!is_ram) pat = 5'b11000;
        else if (rd)      pat = 5'b00110;
        else              pat = 5'b00101;
        if (rd && !wr && !exp_err) sb_last = rd_val;
        sb_q.push_back('{rdata: sb_last, err: exp_err});
        cpu_rd    = rd;
        cpu_wr    = wr;
        cpu_addr  = addr;
        cpu_wdata = wd;
        got = 0;
        for (int c = 1; c <= 20 && !got; c++) begin
            @(negedge clk);
            if (cpu_ready) begin
                got = 1;
                e = sb_q.pop_front();
                chk({tag, "_lat"},   64'(c), 64'(lat));
                chk({tag, "_rdata"}, 64'(cpu_rdata), 64'(e.rdata));
                chk({tag, "_err"},   64'(cpu_err), 64'(e.err));
                chk({tag, "_rstrb"}, 64'(strobes()), 64'd0);
            end else begin
                chk({tag, "_strb"}, 64'(strobes()), (c < lat) ? 64'(pat) : 64'd0);
                chk({tag, "_noerr"}, 64'(cpu_err), 64'd0);
                if (c < lat && !exp_err) begin
                    if (is_ram) chk({tag, "_ramaddr"}, 64'(ram_addr), 64'(addr[9:0]));
                    else        chk({tag, "_romaddr"}, 64'(rom_addr), 64'(addr));
                    if (is_ram && wr) chk({tag, "_wdata"}, 64'(ram_wdata), 64'(wd));
                end
            end
        end
        if (!got) chk({tag, "_timeout"}, 64'(cpu_ready), 64'd1);
        repeat (hold) begin
            @(negedge clk);
            chk({tag, "_hold"}, 64'({strobes(), cpu_ready, cpu_err}), 64'd0);
        end
        cpu_rd = 1'b0;
        cpu_wr = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk({tag, "_idle"}, 64'({strobes(), cpu_ready, cpu_err}), 64'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        n_chk     = 0;
        n_fail    = 0;
        sb_last   = 8'h00;
        rst       = 1'b1;
        cpu_halt  = 1'b0;
        cpu_rd    = 1'b0;
        cpu_wr    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        rom_data  = 8'h00;
        for (int i = 0; i < 1024; i++) ram_mem[i] = 8'h00;

        repeat (2) @(negedge clk);
        chk("reset_outs", 64'(all_outs()), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // ROM read, request held 5 cycles past ready: exactly one access.
        rom_data = 8'hA5;
        run_req("rom_rd", 1'b1, 1'b0, 13'h0005, 8'h00, 4, 1'b0, 8'hA5, 5);

        // RAM write then aliased read of the same cell.
        run_req("ram_wr", 1'b0, 1'b1, 13'h1805, 8'h3C, 3, 1'b0, 8'h00, 0);
        chk("ram_cell", 64'(ram_mem[5]), 64'h3C);
        run_req("ram_rd", 1'b1, 1'b0, 13'h1C05, 8'h00, 3, 1'b0, 8'h3C, 0);

        // Error cases: write into ROM, and both strobes at once.
        run_req("rom_wr", 1'b0, 1'b1, 13'h0100, 8'h77, 1, 1'b1, 8'h00, 0);
        run_req("both",   1'b1, 1'b1, 13'h1800, 8'h55, 1, 1'b1, 8'h00, 0);
        chk("ram0_untouched", 64'(ram_mem[0]), 64'h00);

        // Halt blocks acceptance of a pending read for 10 cycles.
        rom_data = 8'h5A;
        cpu_halt = 1'b1;
        cpu_rd   = 1'b1;
        cpu_addr = 13'h0010;
        repeat (10) begin
            @(negedge clk);
            chk("halt_quiet", 64'({strobes(), cpu_ready}), 64'd0);
        end
        cpu_halt = 1'b0;
        run_req("halt_rel", 1'b1, 1'b0, 13'h0010, 8'h00, 4, 1'b0, 8'h5A, 0);

        // Reset during cycle 2 of a ROM read.
        rom_data = 8'h11;
        cpu_rd   = 1'b1;
        cpu_addr = 13'h0003;
        repeat (2) @(negedge clk);
        chk("mid_rom_ena", 64'(rom_ena), 64'd1);
        #2 rst = 1'b1;
        #1 chk("rst_mid_outs", 64'(all_outs()), 64'd0);
        @(negedge clk);
        chk("rst_no_ready", 64'(cpu_ready), 64'd0);
        rst    = 1'b0;
        cpu_rd = 1'b0;
        sb_last = 8'h00;
        @(negedge clk);
        chk("rst_rdata", 64'(cpu_rdata), 64'd0);
        rom_data = 8'h77;
        run_req("post_rst", 1'b1, 1'b0, 13'h0007, 8'h00, 4, 1'b0, 8'h77, 0);

        chk("sb_empty", 64'(sb_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
